// File: rtl/kart_motion.sv
// -----------------------------------------------------------------------------
// kart_motion
// Per-frame kart kinematics. Once per accepted frame tick the block latches the
// driver buttons, updates heading and speed, looks up cos/sin of the new
// heading, advances a fixed-point position and clamps it to the track bounds.
// The published heading, position and speed change together in one cycle.
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous active-high reset
//   frame_tick_in  one-cycle pulse, starts an update when idle
//   left_in, right_in, accel_in, brake_in   synchronized button levels
//   direction      published heading in degrees, 0..359 (0 = +x, 90 = +y)
//   player_x/y     published integer position
//   speed_out      published speed, 0..MAX_SPEED
//   busy_out       high while an update is in flight
//   update_out     one-cycle pulse when new outputs are published
// -----------------------------------------------------------------------------
module kart_motion #(
    parameter int START_X      = 192,
    parameter int START_Y      = 192,
    parameter int START_DIR    = 90,
    parameter int TURN_STEP    = 3,
    parameter int MAX_SPEED    = 8,
    parameter int COAST_FRAMES = 4,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 1023,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 767
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        accel_in,
    input  logic        brake_in,
    output logic [8:0]  direction,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic [3:0]  speed_out,
    output logic        busy_out,
    output logic        update_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TURN   = 3'd1;
    localparam logic [2:0] S_TRIG   = 3'd2;
    localparam logic [2:0] S_MOVE   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam int              CW         = (COAST_FRAMES > 1) ? $clog2(COAST_FRAMES) : 1;
    localparam logic [CW-1:0]   COAST_LAST = CW'(COAST_FRAMES - 1);
    localparam logic [8:0]      STEP       = 9'(TURN_STEP);
    localparam logic [8:0]      WRAP_LEFT  = 9'(360 - TURN_STEP);
    localparam logic [3:0]      SPEED_MAX  = 4'(MAX_SPEED);
    localparam logic signed [11:0] X_LO    = 12'(X_MIN);
    localparam logic signed [11:0] X_HI    = 12'(X_MAX);
    localparam logic signed [11:0] Y_LO    = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI    = 12'(Y_MAX);
    localparam logic signed [19:0] POS_X0  = {12'(START_X), 8'd0};
    localparam logic signed [19:0] POS_Y0  = {12'(START_Y), 8'd0};

    // Quarter-wave table: round(256 * sin(k deg)), k = 0..90.
    localparam logic [8:0] SIN_LUT [91] = '{
          0,   4,   9,  13,  18,  22,  27,  31,  36,  40,
         44,  49,  53,  58,  62,  66,  71,  75,  79,  83,
         88,  92,  96, 100, 104, 108, 112, 116, 120, 124,
        128, 132, 136, 139, 143, 147, 150, 154, 158, 161,
        165, 168, 171, 175, 178, 181, 184, 187, 190, 193,
        196, 199, 202, 204, 207, 210, 212, 215, 217, 219,
        222, 224, 226, 228, 230, 232, 234, 236, 237, 239,
        241, 242, 243, 245, 246, 247, 248, 249, 250, 251,
        252, 253, 254, 254, 255, 255, 255, 256, 256, 256,
        256
    };

    logic [2:0]         r_state;
    logic               r_left, r_right, r_accel, r_brake;
    logic [8:0]         r_dir;
    logic [3:0]         r_speed;
    logic [CW-1:0]      r_coast;
    logic signed [9:0]  r_cos, r_sin;
    logic signed [19:0] r_pos_x, r_pos_y;

    // ---------------- heading update (TURN) ----------------
    logic [9:0] w_dir_sum;
    logic [8:0] w_dir_next;
    assign w_dir_sum = {1'b0, r_dir} + {1'b0, STEP};

    // NOTE: every output of a combinational block gets a default assignment
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_dir_next = r_dir;
        if (r_left && !r_right)
            w_dir_next = (r_dir >= STEP) ? r_dir - STEP : r_dir + WRAP_LEFT;
        else if (r_right && !r_left)
            w_dir_next = (w_dir_sum >= 10'd360) ? 9'(w_dir_sum - 10'd360) : w_dir_sum[8:0];
    end

    // ---------------- speed update (TURN) ----------------
    logic [3:0]    w_speed_next;
    logic [CW-1:0] w_coast_next;

    always_comb begin
        w_speed_next = r_speed;
        w_coast_next = r_coast;
        if (r_brake) begin
            // Brake wins over accel when both are held.
            w_coast_next = '0;
            if (r_speed != 4'd0) w_speed_next = r_speed - 4'd1;
        end else if (r_accel) begin
            w_coast_next = '0;
            if (r_speed < SPEED_MAX) w_speed_next = r_speed + 4'd1;
        end else if (r_coast == COAST_LAST) begin
            w_coast_next = '0;
            if (r_speed != 4'd0) w_speed_next = r_speed - 4'd1;
        end else begin
            w_coast_next = r_coast + CW'(1);
        end
    end

    // ---------------- quadrant folding (TRIG) ----------------
    logic [6:0]        w_sin_idx, w_cos_idx;
    logic              w_sin_neg, w_cos_neg;
    logic [8:0]        w_sin_mag, w_cos_mag;
    logic signed [9:0] w_sin_val, w_cos_val;

    always_comb begin
        w_sin_idx = 7'(r_dir);
        w_cos_idx = 7'(9'd90 - r_dir);
        w_sin_neg = 1'b0;
        w_cos_neg = 1'b0;
        if (r_dir > 9'd270) begin
            w_sin_idx = 7'(9'd360 - r_dir);
            w_cos_idx = 7'(r_dir - 9'd270);
            w_sin_neg = 1'b1;
        end else if (r_dir > 9'd180) begin
            w_sin_idx = 7'(r_dir - 9'd180);
            w_cos_idx = 7'(9'd270 - r_dir);
            w_sin_neg = 1'b1;
            w_cos_neg = 1'b1;
        end else if (r_dir > 9'd90) begin
            w_sin_idx = 7'(9'd180 - r_dir);
            w_cos_idx = 7'(r_dir - 9'd90);
            w_cos_neg = 1'b1;
        end
    end

    assign w_sin_mag = SIN_LUT[w_sin_idx];
    assign w_cos_mag = SIN_LUT[w_cos_idx];
    assign w_sin_val = w_sin_neg ? -$signed({1'b0, w_sin_mag}) : $signed({1'b0, w_sin_mag});
    assign w_cos_val = w_cos_neg ? -$signed({1'b0, w_cos_mag}) : $signed({1'b0, w_cos_mag});

    // ---------------- position step (MOVE) ----------------
    logic signed [14:0] w_spd_s, w_mul_x, w_mul_y;
    assign w_spd_s = 15'($signed({1'b0, r_speed}));
    assign w_mul_x = w_spd_s * 15'(r_cos);
    assign w_mul_y = w_spd_s * 15'(r_sin);

    // ---------------- clamp (COMMIT) ----------------
    // The integer part is the arithmetic floor, so -0.5 px reads as -1 and clamps.
    logic signed [11:0] w_int_x, w_int_y;
    logic               w_lo_x, w_hi_x, w_lo_y, w_hi_y, w_wall;
    logic signed [19:0] w_pos_x_c, w_pos_y_c;

    assign w_int_x = r_pos_x[19:8];
    assign w_int_y = r_pos_y[19:8];
    assign w_lo_x  = w_int_x < X_LO;
    assign w_hi_x  = w_int_x > X_HI;
    assign w_lo_y  = w_int_y < Y_LO;
    assign w_hi_y  = w_int_y > Y_HI;
    assign w_wall  = w_lo_x || w_hi_x || w_lo_y || w_hi_y;

    assign w_pos_x_c = w_lo_x ? {X_LO, 8'd0} : (w_hi_x ? {X_HI, 8'd0} : r_pos_x);
    assign w_pos_y_c = w_lo_y ? {Y_LO, 8'd0} : (w_hi_y ? {Y_HI, 8'd0} : r_pos_y);

    assign busy_out = (r_state != S_IDLE);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk_in) begin
        update_out <= 1'b0;
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_accel   <= 1'b0;
            r_brake   <= 1'b0;
            r_dir     <= 9'(START_DIR);
            r_speed   <= 4'd0;
            r_coast   <= '0;
            r_cos     <= '0;
            r_sin     <= '0;
            r_pos_x   <= POS_X0;
            r_pos_y   <= POS_Y0;
            direction <= 9'(START_DIR);
            player_x  <= 11'(START_X);
            player_y  <= 11'(START_Y);
            speed_out <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick_in) begin
                        r_left  <= left_in;
                        r_right <= right_in;
                        r_accel <= accel_in;
                        r_brake <= brake_in;
                        r_state <= S_TURN;
                    end
                end
                S_TURN: begin
                    r_dir   <= w_dir_next;
                    r_speed <= w_speed_next;
                    r_coast <= w_coast_next;
                    r_state <= S_TRIG;
                end
                S_TRIG: begin
                    r_cos   <= w_cos_val;
                    r_sin   <= w_sin_val;
                    r_state <= S_MOVE;
                end
                S_MOVE: begin
                    r_pos_x <= r_pos_x + 20'(w_mul_x);
                    r_pos_y <= r_pos_y + 20'(w_mul_y);
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_pos_x    <= w_pos_x_c;
                    r_pos_y    <= w_pos_y_c;
                    r_speed    <= w_wall ? 4'd0 : r_speed;
                    direction  <= r_dir;
                    player_x   <= w_pos_x_c[18:8];
                    player_y   <= w_pos_y_c[18:8];
                    speed_out  <= w_wall ? 4'd0 : r_speed;
                    update_out <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kart_motion.sv
// -----------------------------------------------------------------------------
// tb_kart_motion
// Self-checking bench for kart_motion. A frame-level reference model computes
// each update in one step with real-valued trig and integer arithmetic, then
// schedules the result four edges later; a compare loop checks every output on
// every falling edge. Directed frames pin the model with hand-worked values,
// followed by randomized frames, button noise, stray ticks and resets.
// -----------------------------------------------------------------------------
module tb_kart_motion;

    localparam int START_X = 192, START_Y = 192, START_DIR = 90;
    localparam int STEP = 3, MAXS = 8, COAST = 4;
    localparam int XMIN = 0, XMAX = 1023, YMIN = 0, YMAX = 767;
    localparam real PI = 3.14159265358979;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_tick_in = 1'b0;
    logic        left_in = 1'b0, right_in = 1'b0, accel_in = 1'b0, brake_in = 1'b0;
    logic [8:0]  direction;
    logic [10:0] player_x, player_y;
    logic [3:0]  speed_out;
    logic        busy_out, update_out;

    int n_vec = 0;
    int n_err = 0;

    kart_motion dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .frame_tick_in (frame_tick_in),
        .left_in       (left_in),
        .right_in      (right_in),
        .accel_in      (accel_in),
        .brake_in      (brake_in),
        .direction     (direction),
        .player_x      (player_x),
        .player_y      (player_y),
        .speed_out     (speed_out),
        .busy_out      (busy_out),
        .update_out    (update_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_dir, m_speed, m_coast, m_px, m_py;   // kart state, position in 1/256 px
    int p_dir, p_x, p_y, p_speed;              // published values
    int n_dir, n_x, n_y, n_speed;              // result waiting to be published
    int m_cnt;                                 // edges left until publish, 0 = idle
    bit m_upd;

    function automatic int q8(input real v);
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        return -$rtoi($floor(-v + 0.5));
    endfunction

    function automatic int trig_cos(input int d);
        return q8(256.0 * $cos(d * PI / 180.0));
    endfunction

    function automatic int trig_sin(input int d);
        return q8(256.0 * $sin(d * PI / 180.0));
    endfunction

    task automatic model_reset();
        m_dir = START_DIR; m_speed = 0; m_coast = 0;
        m_px = START_X * 256; m_py = START_Y * 256;
        p_dir = START_DIR; p_x = START_X; p_y = START_Y; p_speed = 0;
        m_cnt = 0; m_upd = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit a, input bit b);
        bit hit;
        if (l && !r)      m_dir = (m_dir + 360 - STEP) % 360;
        else if (r && !l) m_dir = (m_dir + STEP) % 360;
        if (b) begin
            m_coast = 0;
            if (m_speed > 0) m_speed--;
        end else if (a) begin
            m_coast = 0;
            if (m_speed < MAXS) m_speed++;
        end else begin
            m_coast++;
            if (m_coast == COAST) begin
                m_coast = 0;
                if (m_speed > 0) m_speed--;
            end
        end
        m_px += m_speed * trig_cos(m_dir);
        m_py += m_speed * trig_sin(m_dir);
        hit = 0;
        if ((m_px >>> 8) < XMIN) begin m_px = XMIN * 256; hit = 1; end
        else if ((m_px >>> 8) > XMAX) begin m_px = XMAX * 256; hit = 1; end
        if ((m_py >>> 8) < YMIN) begin m_py = YMIN * 256; hit = 1; end
        else if ((m_py >>> 8) > YMAX) begin m_py = YMAX * 256; hit = 1; end
        if (hit) m_speed = 0;
        n_dir = m_dir; n_x = m_px >>> 8; n_y = m_py >>> 8; n_speed = m_speed;
    endtask

    // Advance the model across the coming rising edge using the inputs it will see.
    task automatic model_step();
        if (rst_in) begin
            model_reset();
        end else begin
            m_upd = 0;
            if (m_cnt == 0) begin
                if (frame_tick_in) begin
                    model_frame(left_in, right_in, accel_in, brake_in);
                    m_cnt = 4;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    p_dir = n_dir; p_x = n_x; p_y = n_y; p_speed = n_speed;
                    m_upd = 1;
                end
            end
        end
    endtask

    // Compare loop: outputs after the previous rising edge, checked mid-cycle.
    initial begin
        model_reset();
        forever begin
            @(negedge clk_in);
            check("direction", direction, p_dir);
            check("player_x", player_x, p_x);
            check("player_y", player_y, p_y);
            check("speed_out", speed_out, p_speed);
            check("busy_out", busy_out, (m_cnt != 0));
            check("update_out", update_out, m_upd);
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_buttons(input logic [3:0] btn);
        {left_in, right_in, accel_in, brake_in} = btn;
    endtask

    // One accepted frame; buttons are scrambled while busy. Returns the number
    // of edges from the tick-sampling edge to the update pulse (0 on timeout).
    task automatic do_frame(input logic [3:0] btn, output int lat);
        @(posedge clk_in); #1;
        set_buttons(btn);
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1;
        frame_tick_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            set_buttons(4'($urandom_range(0, 15)));
            @(posedge clk_in); #1;
            if (update_out) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 4);
    endtask

    task automatic count_updates(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_in); #1;
            if (update_out) cnt++;
        end
    endtask

    task automatic rand_frame();
        int rst_at;
        rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
        repeat ($urandom_range(0, 3)) @(posedge clk_in);
        #1;
        set_buttons(4'($urandom_range(0, 15)));
        frame_tick_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_in); #1;
            frame_tick_in = ($urandom_range(0, 3) == 0);
            set_buttons(4'($urandom_range(0, 15)));
            rst_in = (k == rst_at);
        end
        frame_tick_in = 1'b0;
        rst_in = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, cnt;

        // Model pins against hand-worked table entries.
        check("model_sin30", trig_sin(30), 128);
        check("model_sin45", trig_sin(45), 181);
        check("model_sin60", trig_sin(60), 222);
        check("model_sin90", trig_sin(90), 256);
        check("model_cos90", trig_cos(90), 0);
        check("model_cos180", trig_cos(180), -256);

        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        check("rst_dir", direction, 90);
        check("rst_x", player_x, 192);
        check("rst_y", player_y, 192);
        check("rst_speed", speed_out, 0);
        check("rst_update", update_out, 0);
        check("rst_busy", busy_out, 0);

        // No buttons: position unchanged, latency checked inside do_frame.
        do_frame(4'b0000, lat);
        check("idle_x", player_x, 192);
        check("idle_y", player_y, 192);

        // Accelerate along +y.
        do_frame(4'b0010, lat); check("acc1_speed", speed_out, 1); check("acc1_y", player_y, 193);
        do_frame(4'b0010, lat); check("acc2_speed", speed_out, 2); check("acc2_y", player_y, 195);
        do_frame(4'b0010, lat); check("acc3_speed", speed_out, 3); check("acc3_y", player_y, 198);
        do_frame(4'b0010, lat); check("acc4_speed", speed_out, 4); check("acc4_y", player_y, 202);
        check("acc_x", player_x, 192);

        // Brake together with accel decrements.
        do_frame(4'b0011, lat); check("brake_acc_speed", speed_out, 3); check("brake_acc_y", player_y, 205);
        repeat (3) do_frame(4'b0001, lat);
        check("stop_speed", speed_out, 0);
        check("stop_y", player_y, 208);

        // Turn left to heading 0, then exercise the wrap in both directions.
        repeat (30) do_frame(4'b1000, lat);
        check("turn_to_0", direction, 0);
        do_frame(4'b1000, lat); check("wrap_left", direction, 357);
        do_frame(4'b0100, lat); check("wrap_right", direction, 0);
        do_frame(4'b1100, lat); check("both_turn", direction, 0);

        // Speed 1 along +x, then coast from speed 2.
        do_frame(4'b0010, lat); check("x_step1", player_x, 193);
        do_frame(4'b0000, lat); check("x_step2", player_x, 194); check("x_step2_speed", speed_out, 1);
        do_frame(4'b0010, lat); check("coast_start", speed_out, 2);
        repeat (4) do_frame(4'b0000, lat);
        check("coast4_speed", speed_out, 1);
        check("coast4_x", player_x, 203);
        repeat (4) do_frame(4'b0000, lat);
        check("coast8_speed", speed_out, 0);
        check("coast8_x", player_x, 206);

        // Drive into the right wall.
        begin
            bit hit = 0;
            for (int f = 0; f < 200 && !hit; f++) begin
                do_frame(4'b0010, lat);
                if (player_x == 11'd1023 && speed_out == 4'd0) hit = 1;
            end
            check("wall_reached", hit, 1);
        end
        check("wall_x", player_x, 1023);
        check("wall_speed", speed_out, 0);

        // Tick held high through a whole update: exactly one publish.
        @(posedge clk_in); #1;
        set_buttons(4'b0000);
        frame_tick_in = 1'b1;
        repeat (5) @(posedge clk_in);
        #1 frame_tick_in = 1'b0;
        count_updates(8, cnt);
        check("busy_ticks_updates", cnt, 0);
        check("busy_ticks_after", busy_out, 0);

        // Reset sampled while in MOVE: nothing published, reset values return.
        @(posedge clk_in); #1;
        set_buttons(4'b0010);
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1 frame_tick_in = 1'b0;   // E0
        @(posedge clk_in); #1;                         // E1
        @(posedge clk_in); #1 rst_in = 1'b1;           // E2, reset lands on E3
        @(posedge clk_in); #1 rst_in = 1'b0;
        count_updates(8, cnt);
        check("mid_reset_updates", cnt, 0);
        check("mid_reset_dir", direction, 90);
        check("mid_reset_x", player_x, 192);
        check("mid_reset_y", player_y, 192);
        check("mid_reset_speed", speed_out, 0);

        // Randomized frames with noise, stray ticks and occasional resets.
        repeat (300) rand_frame();
        repeat (10) @(posedge clk_in);

        @(negedge clk_in); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kart_motion.md
# kart_motion

Per-frame kart kinematics engine that produces the `direction`, `player_x` and `player_y` values consumed by `racer_view`. It samples driver buttons once per frame tick and updates heading, speed and fixed-point position. It publishes all three outputs atomically, so the renderer never sees a partially updated kart. It sits between input conditioning (debounced, synchronized buttons) and the pixel pipeline, one instance per locally driven kart.

## Interface
- `START_X`, default 192: integer x position after reset.
- `START_Y`, default 192: integer y position after reset.
- `START_DIR`, default 90: heading after reset, in degrees (0..359).
- `TURN_STEP`, default 3: degrees turned per frame.
- `MAX_SPEED`, default 8: speed ceiling (≤15).
- `COAST_FRAMES`, default 4: consecutive coasting frames per 1-unit speed decay.
- `X_MIN` / `X_MAX`, default 0 / 1023: x clamp bounds (integer pixels).
- `Y_MIN` / `Y_MAX`, default 0 / 767: y clamp bounds (integer pixels).
- `clk_in`  in  1  system clock; the block has one clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `frame_tick_in`  in  1  one-cycle pulse per frame; starts an update.
- `left_in`, `right_in`, `accel_in`, `brake_in`  in  1 each  button levels, already synchronized.
- `direction`  out  9  heading in degrees, 0..359. 0 = +x, 90 = +y (screen down).
- `player_x`  out  11  integer x position.
- `player_y`  out  11  integer y position.
- `speed_out`  out  4  current speed, 0..MAX_SPEED.
- `busy_out`  out  1  high while an update is in flight.
- `update_out`  out  1  one-cycle pulse when new outputs are published.

## Operation
- Internal position: signed 20 bits per axis (11 integer bits plus sign, 8 fractional bits). Outputs carry the integer part only.
- FSM states: IDLE → TURN → TRIG → MOVE → COMMIT → IDLE. Each state lasts exactly one cycle.
- IDLE: on `frame_tick_in`=1, latch all four buttons and go to TURN. `frame_tick_in` in any other state is ignored; it is not queued.
- TURN, heading:
  - left only: dir − TURN_STEP, wrapping below 0 by adding 360.
  - right only: dir + TURN_STEP, wrapping ≥360 by subtracting 360.
  - both or neither: heading unchanged.
- TURN, speed:
  - brake pressed (regardless of accel): speed − 1, floor 0.
  - accel only: speed + 1, ceiling MAX_SPEED.
  - neither: increment the coast counter. When it reaches COAST_FRAMES, decrement speed (floor 0) and clear the counter.
  - Any accel or brake press clears the coast counter.
- TRIG: look up signed Q1.8 values cos(dir) and sin(dir) from the new heading.
  - A 91-entry quarter-wave table of round(256·sin k°) is used, k = 0..90. Reference entries: sin 0 = 0, 30 = 128, 45 = 181, 60 = 222, 90 = 256.
  - Quadrant folding: cos(d) = sin(90−d) with sign by quadrant.
  - Results are registered.
- MOVE: pos_x += speed·cos and pos_y += speed·sin. Each product is at most ±2048 (8 px per frame at speed 8).
- COMMIT:
  - Clamp each axis's integer part to [MIN, MAX]. A clamped axis gets integer = bound and fraction 0.
  - If either axis clamps, force speed to 0 (wall hit).
  - Register `direction`, `player_x`, `player_y` and `speed_out` together, and pulse `update_out`.
- The published outputs hold their values between updates.

## Timing
- Reset values:
  - state IDLE; `direction`=START_DIR; `player_x`=START_X; `player_y`=START_Y; fractions 0.
  - `speed_out`=0; coast counter 0; `busy_out`=0; `update_out`=0.
- Reset takes priority in any state. An in-flight update is abandoned and nothing is published.
- Let edge E0 be the edge that samples `frame_tick_in`=1 in IDLE:
  - `busy_out` is high after edges E0..E3.
  - New outputs and `update_out`=1 appear after E4, with `busy_out`=0.
  - Latency is 4 cycles.
- A tick coincident with the COMMIT cycle is ignored. The earliest accepted next tick is the cycle after `update_out`.
- Buttons are sampled only at E0. Changes during busy have no effect.

## Test plan
- Reset → direction 90, x 192, y 192, speed 0, `update_out` 0; a tick with no buttons leaves the position unchanged and pulses `update_out` exactly 4 cycles after the tick edge.
- dir 90, accel held for 4 ticks → speeds 1, 2, 3, 4; y = 193, 195, 198, 202; x stays 192.
- Heading wrap: dir 1 with left → 358; dir 358 with right → 1; both pressed → unchanged.
- dir 0, speed 1 → x +1 per tick. Coast from speed 2 → speed decays to 1 after 4 ticks and to 0 after 8.
- x = 1020, dir 0, speed 8 → x clamps to 1023, speed 0. Brake + accel together → speed decrements.
- Ticks during busy are ignored (one `update_out` per accepted tick). Reset asserted in the MOVE state → reset values, no `update_out`.
